// File: rtl/fifo_word_packer.sv
// Drains a WIDTH-bit FIFO and packs NUM_WORDS consecutive words into one wide operand.
// Define PACKER_MSW_FIRST_EN to place the first popped word in the most-significant slot.
module fifo_word_packer #(
    parameter int WIDTH     = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       fifo_rd_en,
    input  logic [WIDTH-1:0]           fifo_rd_data,
    input  logic                       fifo_empty,
    input  logic                       clear,
    output logic                       out_valid,
    output logic [WIDTH*NUM_WORDS-1:0] out_data,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int OW = WIDTH * NUM_WORDS;
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS);
    localparam logic [CW-1:0] PREV_CNT = CW'(NUM_WORDS - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]   recv_cnt_q, recv_cnt_d;
    logic            rd_pend_q, rd_pend_d;
    logic [OW-1:0]   shreg_q, shreg_d;
    logic            pop;

    // Output handshake: an operand transfers on any posedge where out_valid and
    // out_ready are both high; out_valid/out_data stay stable until then.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        rd_pend_d   = 1'b0;
        shreg_d     = shreg_q;
        pop         = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (clear) begin
                    // Dropping rd_pend discards the word of a pop already in flight.
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    shreg_d     = '0;
                end else begin
                    pop       = !fifo_empty && (issue_cnt_q < LAST_CNT);
                    rd_pend_d = pop;
                    if (pop) begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end
                    if (rd_pend_q) begin
`ifdef PACKER_MSW_FIRST_EN
                        shreg_d = {shreg_q[OW-WIDTH-1:0], fifo_rd_data};
`else
                        shreg_d = {fifo_rd_data, shreg_q[OW-1:WIDTH]};
`endif
                        recv_cnt_d = recv_cnt_q + 1'b1;
                        if (recv_cnt_q == PREV_CNT) begin
                            state_d = ST_OUT;
                        end
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_FILL;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            shreg_q     <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            rd_pend_q   <= rd_pend_d;
            shreg_q     <= shreg_d;
        end
    end

    assign fifo_rd_en = pop && rst_n;
    assign out_valid  = (state_q == ST_OUT);
    assign out_data   = shreg_q;
    assign busy       = (state_q == ST_FILL) && ((issue_cnt_q != '0) || (recv_cnt_q != '0));

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: FIFO environment, queue-based reference model,
// per-cycle compare process, directed scenarios with literal expectations, then random traffic.
module tb_fifo_word_packer;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int OW = W * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic          clear = 1'b0;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [W-1:0]  fifo_q[$];
    logic [OW-1:0] exp_q[$];
    int            pop_cycs[$];
    int            valid_cycs[$];

    // Reference model: words received so far, words requested, a pop in flight, a held operand.
    logic [W-1:0]  m_words[$];
    int            m_issued = 0;
    bit            m_pend = 1'b0;
    bit            m_hold = 1'b0;
    logic [OW-1:0] m_data = '0;

    fifo_word_packer #(.WIDTH(W), .NUM_WORDS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .clear        (clear),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lit(input logic [63:0] lsw_first, input logic [63:0] msw_first);
`ifdef PACKER_MSW_FIRST_EN
        return msw_first;
`else
        return lsw_first;
`endif
    endfunction

    function automatic logic [OW-1:0] pack_words();
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
`ifdef PACKER_MSW_FIRST_EN
            r[(N-1-k)*W +: W] = m_words[k];
`else
            r[k*W +: W] = m_words[k];
`endif
        end
        return r;
    endfunction

    function automatic bit exp_rd_en();
        return rst_n && !m_hold && !fifo_empty && (m_issued < N) && !clear;
    endfunction

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic push_seq(input logic [W-1:0] first, input int cnt);
        for (int i = 0; i < cnt; i++) push(first + W'(i));
    endtask

    // Clock-and-FIFO environment: pop on the edge, read data appears the following cycle.
    task automatic fifo_proc();
        forever begin
            @(posedge clk);
            cyc++;
            if (fifo_rd_en && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
            #2;
            fifo_empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic model_proc();
        bit rd;
        forever begin
            @(posedge clk);
            rd = exp_rd_en();
            if (!rst_n) begin
                m_words.delete();
                m_issued = 0;
                m_pend   = 1'b0;
                m_hold   = 1'b0;
                m_data   = '0;
                exp_q.delete();
            end else if (m_hold) begin
                if (out_ready) begin
                    m_hold   = 1'b0;
                    m_issued = 0;
                    m_words.delete();
                end
            end else if (clear) begin
                m_issued = 0;
                m_pend   = 1'b0;
                m_words.delete();
            end else begin
                if (m_pend) begin
                    m_words.push_back(fifo_rd_data);
                    if (m_words.size() == N) begin
                        m_hold = 1'b1;
                        m_data = pack_words();
                        exp_q.push_back(m_data);
                    end
                end
                m_pend = rd;
                if (rd) m_issued++;
            end
        end
    endtask

    task automatic compare_proc();
        forever begin
            @(negedge clk);
            if (fifo_rd_en) pop_cycs.push_back(cyc);
            if (out_valid) valid_cycs.push_back(cyc);
            if (chk_en) begin
                check("rd_en", 64'(fifo_rd_en), 64'(exp_rd_en()));
                check("out_valid", 64'(out_valid), 64'(m_hold));
                check("busy", 64'(busy), 64'(!m_hold && (m_issued > 0 || m_words.size() > 0)));
                if (m_hold) check("out_data", 64'(out_data), 64'(m_data));
                if (out_valid && out_ready && rst_n) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL accept: operand %h offered, none expected", out_data);
                    end else begin
                        check("accepted", 64'(out_data), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: out_valid got 0 expected 1 within %0d cycles", name, max_cycles);
        end
    endtask

    initial begin
        int p0, v0;
        fork
            fifo_proc();
            model_proc();
            compare_proc();
        join_none

        // Reset
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic pack
        @(posedge clk);
        #1 out_ready = 1'b1;
        p0 = pop_cycs.size();
        v0 = valid_cycs.size();
        push_seq(16'h0001, 4);
        wait_valid("basic", 20);
        check("basic_data", 64'(out_data), lit(64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004));
        check("basic_model", 64'(m_data), lit(64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004));
        repeat (4) @(negedge clk);
        check("basic_pops", 64'(pop_cycs.size() - p0), 64'd4);
        check("basic_valid_cycles", 64'(valid_cycs.size() - v0), 64'd1);
        if (pop_cycs.size() >= p0 + 4 && valid_cycs.size() > v0) begin
            check("basic_latency", 64'(valid_cycs[v0] - pop_cycs[p0]), 64'(N + 1));
            check("basic_consecutive", 64'(pop_cycs[p0+3] - pop_cycs[p0]), 64'd3);
        end

        // Backpressure
        @(posedge clk);
        #1 out_ready = 1'b0;
        push_seq(16'h0011, 8);
        wait_valid("bp_first", 20);
        p0 = pop_cycs.size();
        repeat (10) begin
            @(negedge clk);
            check("bp_hold", 64'(out_data), lit(64'h0014_0013_0012_0011, 64'h0011_0012_0013_0014));
        end
        check("bp_no_pops", 64'(pop_cycs.size() - p0), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        wait_valid("bp_second", 20);
        check("bp_second_data", 64'(out_data), lit(64'h0018_0017_0016_0015, 64'h0015_0016_0017_0018));

        // Starvation
        @(posedge clk);
        #1 push(16'hA001);
        push(16'hA002);
        repeat (4) @(posedge clk);
        repeat (6) begin
            @(negedge clk);
            check("starve_busy", 64'(busy), 64'd1);
            check("starve_no_pop", 64'(fifo_rd_en), 64'd0);
        end
        @(posedge clk);
        #1 push(16'hA003);
        push(16'hA004);
        wait_valid("starve", 20);
        check("starve_data", 64'(out_data), lit(64'hA004_A003_A002_A001, 64'hA001_A002_A003_A004));

        // Clear with two words captured and a third in flight
        @(posedge clk);
        #1 push(16'hDEAD);
        push(16'hBEEF);
        push(16'hCAFE);
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("clear_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 push_seq(16'h0101, 4);
        wait_valid("clear", 20);
        check("clear_data", 64'(out_data), lit(64'h0104_0103_0102_0101, 64'h0101_0102_0103_0104));

        // Reset while an operand is held
        @(posedge clk);
        #1 out_ready = 1'b0;
        push_seq(16'h0B01, 4);
        wait_valid("rst_out_fill", 20);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        push_seq(16'h0C01, 4);
        wait_valid("rst_out_next", 20);
        check("rst_out_next_data", 64'(out_data), lit(64'h0C04_0C03_0C02_0C01, 64'h0C01_0C02_0C03_0C04));

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) push(W'($urandom_range(0, 65535)));
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #1 clear = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("drain_scoreboard", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
